// File: rtl/filter_scheduler_if.sv
// Request handshake plus the passively monitored video_in AXI-Stream signals.
interface filter_scheduler_if #(
    parameter int unsigned WHICH_FILTER_WIDTH = 4,
    parameter int unsigned COLOR_WIDTH        = 8
);
    logic [WHICH_FILTER_WIDTH-1:0] req_filter;
    logic                          req_valid;
    logic                          req_ready;
    logic [3*COLOR_WIDTH-1:0]      mon_tdata;
    logic                          mon_tuser;
    logic                          mon_tvalid;
    logic                          mon_tready;

    modport master (
        output req_filter, req_valid, mon_tdata, mon_tuser, mon_tvalid, mon_tready,
        input  req_ready
    );

    modport slave (
        input  req_filter, req_valid, mon_tdata, mon_tuser, mon_tvalid, mon_tready,
        output req_ready
    );
endinterface

// File: rtl/filter_scheduler.sv
// Frame-aligned filter selection (one-deep request queue, optional auto-cycling)
// and per-frame average colour measured from the monitored input stream.
module filter_scheduler #(
    parameter int unsigned WHICH_FILTER_WIDTH = 4,
    parameter int unsigned COLOR_WIDTH        = 8,
    parameter int unsigned PIX_CNT_WIDTH      = 21
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    filter_scheduler_if.slave             bus,
    input  logic [WHICH_FILTER_WIDTH-1:0] num_filters_i,
    input  logic                          auto_en_i,
    input  logic [7:0]                    auto_period_i,
    output logic [WHICH_FILTER_WIDTH-1:0] active_filter_o,
    output logic                          filter_changed_o,
    output logic                          bad_req_o,
    output logic [3*COLOR_WIDTH-1:0]      avg_color_o,
    output logic                          avg_valid_o,
    output logic                          avg_overrun_o
);
    localparam int unsigned FW     = WHICH_FILTER_WIDTH;
    localparam int unsigned CW     = COLOR_WIDTH;
    localparam int unsigned PW     = PIX_CNT_WIDTH;
    localparam int unsigned SW     = COLOR_WIDTH + PIX_CNT_WIDTH;
    localparam int unsigned STEP_W = $clog2(SW + 1);

    typedef enum logic {
        WAIT_SOF,
        ACCUM
    } acc_state_e;

    logic beat, sof, accept, req_legal;

    assign beat      = bus.mon_tvalid & bus.mon_tready;
    assign sof       = beat & bus.mon_tuser;
    assign accept    = bus.req_valid & bus.req_ready;
    assign req_legal = bus.req_filter < num_filters_i;

    // ---------------- filter selection ----------------
    logic [FW-1:0] active_q, active_d, pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          changed_q, bad_q;
    logic          commit, auto_due;
    logic [FW:0]   inc;

    assign bus.req_ready = ~pend_valid_q;

    // A request accepted on an SOF beat only fills pending; it cannot commit until the next SOF.
    always_comb begin
        active_d     = active_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        frame_cnt_d  = frame_cnt_q;
        commit       = 1'b0;
        auto_due     = auto_en_i && (auto_period_i != 8'd0) &&
                       (frame_cnt_q == auto_period_i - 8'd1);
        inc          = {1'b0, active_q} + (FW + 1)'(1);
        if (sof) begin
            if (pend_valid_q) begin
                active_d     = pend_q;
                pend_valid_d = 1'b0;
                commit       = 1'b1;
            end else if (auto_due) begin
                active_d = (inc >= {1'b0, num_filters_i}) ? '0 : inc[FW-1:0];
                commit   = 1'b1;
            end
        end
        if (accept && req_legal) begin
            pend_valid_d = 1'b1;
            pend_d       = bus.req_filter;
        end
        if (!auto_en_i || commit) begin
            frame_cnt_d = '0;
        end else if (sof) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            active_q     <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
            changed_q    <= 1'b0;
            bad_q        <= 1'b0;
        end else begin
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            changed_q    <= (active_d != active_q);
            bad_q        <= accept & ~req_legal;
        end
    end

    // ---------------- accumulator FSM ----------------
    acc_state_e state_q, state_d;
    logic       acc_load, acc_add, snap;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= WAIT_SOF;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == WAIT_SOF && sof) state_d = ACCUM;
    end

    always_comb begin
        acc_load = sof;
        acc_add  = (state_q == ACCUM) && beat && !sof;
        snap     = (state_q == ACCUM) && sof;
    end

    logic [SW-1:0] sum_q [3];
    logic [PW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned c = 0; c < 3; c++) sum_q[c] <= '0;
            cnt_q <= '0;
        end else if (acc_load) begin
            for (int unsigned c = 0; c < 3; c++) sum_q[c] <= SW'(bus.mon_tdata[c*CW +: CW]);
            cnt_q <= PW'(1);
        end else if (acc_add) begin
            for (int unsigned c = 0; c < 3; c++) sum_q[c] <= sum_q[c] + SW'(bus.mon_tdata[c*CW +: CW]);
            if (cnt_q != '1) cnt_q <= cnt_q + PW'(1);
        end
    end

    // ---------------- serial restoring dividers ----------------
    logic              busy_q, avg_valid_q, overrun_q;
    logic [STEP_W-1:0] step_q;
    logic [PW-1:0]     divisor_q;
    logic [PW-1:0]     rem_q [3];
    logic [SW-1:0]     quo_q [3];
    logic [PW-1:0]     rem_nx [3];
    logic [SW-1:0]     quo_nx [3];
    logic [PW:0]       rem_sh [3];
    logic [PW:0]       rem_sub [3];
    logic [3*CW-1:0]   avg_q;
    logic              div_start, last_step;

    assign div_start = snap & ~busy_q;
    assign last_step = busy_q && (step_q == STEP_W'(SW - 1));

    // The dividend shifts out of quo_q MSB-first while quotient bits shift in at the LSB.
    always_comb begin
        for (int unsigned c = 0; c < 3; c++) begin
            rem_sh[c]  = {rem_q[c], quo_q[c][SW-1]};
            rem_sub[c] = rem_sh[c] - {1'b0, divisor_q};
            if (rem_sh[c] >= {1'b0, divisor_q}) begin
                rem_nx[c] = rem_sub[c][PW-1:0];
                quo_nx[c] = {quo_q[c][SW-2:0], 1'b1};
            end else begin
                rem_nx[c] = rem_sh[c][PW-1:0];
                quo_nx[c] = {quo_q[c][SW-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q      <= 1'b0;
            step_q      <= '0;
            divisor_q   <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int unsigned c = 0; c < 3; c++) begin
                rem_q[c] <= '0;
                quo_q[c] <= '0;
            end
        end else begin
            avg_valid_q <= 1'b0;
            if (div_start) begin
                busy_q    <= 1'b1;
                step_q    <= '0;
                divisor_q <= cnt_q;
                for (int unsigned c = 0; c < 3; c++) begin
                    rem_q[c] <= '0;
                    quo_q[c] <= sum_q[c];
                end
            end else if (busy_q) begin
                step_q <= step_q + STEP_W'(1);
                for (int unsigned c = 0; c < 3; c++) begin
                    rem_q[c] <= rem_nx[c];
                    quo_q[c] <= quo_nx[c];
                end
                if (last_step) begin
                    busy_q      <= 1'b0;
                    avg_valid_q <= 1'b1;
                    for (int unsigned c = 0; c < 3; c++) avg_q[c*CW +: CW] <= quo_nx[c][CW-1:0];
                end
            end
            if (snap && busy_q) overrun_q <= 1'b1;
        end
    end

    assign active_filter_o  = active_q;
    assign filter_changed_o = changed_q;
    assign bad_req_o        = bad_q;
    assign avg_color_o      = avg_q;
    assign avg_valid_o      = avg_valid_q;
    assign avg_overrun_o    = overrun_q;
endmodule

// File: doc/filter_scheduler.md
Name: filter_scheduler

Overview:
- Video-clock-domain controller for the per-pixel filter datapath.
- Accepts filter-change requests, queued one deep, and commits them only at start-of-frame, so a frame never mixes two filters.
- Optionally auto-cycles through filters every N frames.
- Measures the per-channel average colour of each frame by passively monitoring the input AXI-Stream handshake. The result feeds the datapath's avg_color.

Parameters:
- WHICH_FILTER_WIDTH, 4, width of the filter index.
- COLOR_WIDTH, 8, bits per colour channel; pixel is 3*COLOR_WIDTH.
- PIX_CNT_WIDTH, 21, pixel counter width; holds at least 1280*720.

Ports:
- clk  in  1  video clock.
- reset  in  1  synchronous, active-high reset.
- req_filter  in  WHICH_FILTER_WIDTH  requested filter index.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- num_filters  in  WHICH_FILTER_WIDTH  count of legal filters; legal indices are 0..num_filters-1.
- auto_en  in  1  enable auto-cycling.
- auto_period  in  8  frames per auto step; 0 disables auto-cycling.
- mon_tdata  in  3*COLOR_WIDTH  monitored video_in pixel data.
- mon_tuser  in  1  monitored start-of-frame (SOF).
- mon_tvalid  in  1  monitored tvalid.
- mon_tready  in  1  monitored tready.
- active_filter  out  WHICH_FILTER_WIDTH  filter index applied to the current frame.
- filter_changed  out  1  one-cycle pulse when active_filter changes.
- bad_req  out  1  one-cycle pulse when an illegal request is dropped.
- avg_color  out  3*COLOR_WIDTH  average of the last completed frame.
- avg_valid  out  1  one-cycle pulse when avg_color updates.
- avg_overrun  out  1  sticky flag: a frame average was skipped because the divider was busy.

Behaviour:
- Beat = mon_tvalid & mon_tready. SOF beat = beat & mon_tuser.
- Reset values: active_filter=0, avg_color=0, filter_changed=0, bad_req=0, avg_valid=0, avg_overrun=0, req_ready=1. Pending register empty, frame counter 0, accumulators 0, state WAIT_SOF.
- Request queue: one entry. req_ready = !pending_valid.
  - On accept with req_filter >= num_filters: drop the request and pulse bad_req the next cycle. Pending is unchanged.
- Commit on each SOF beat, in priority order:
  - (a) pending_valid: load the pending value and clear pending.
  - (b) else, if auto_en and auto_period!=0 and frame_cnt==auto_period-1: active_filter = active_filter+1, wrapping to 0 when the result is >= num_filters.
  - (c) else: hold.
- frame_cnt increments on each SOF beat. It clears on any commit, or whenever auto_en=0.
- active_filter is registered; the new value is visible the cycle after the SOF beat.
- filter_changed pulses that same cycle, only if the value actually differs.
- A request accepted in the same cycle as an SOF beat is not applied at that SOF; it waits for the next one.
- Accumulator FSM states: WAIT_SOF, ACCUM.
  - WAIT_SOF: ignore beats until the first SOF beat, then begin ACCUM with that pixel.
  - ACCUM: each beat adds the R, G and B channels into sum registers of width COLOR_WIDTH+PIX_CNT_WIDTH and increments pix_cnt. pix_cnt saturates at all-ones.
  - On a later SOF beat (end of frame), snapshot sums and pix_cnt into the divider. In the same cycle, restart accumulation with the SOF pixel as the first sample (sum=pixel, cnt=1).
- Divider: 3 parallel serial restoring dividers computing sum/pix_cnt. Each takes COLOR_WIDTH+PIX_CNT_WIDTH cycles.
  - Quotient is truncated to COLOR_WIDTH, which never overflows because average <= max.
  - On completion, avg_color is registered as {R,G,B} in the same channel order as mon_tdata, and avg_valid pulses.
- Snapshot while the divider is busy: discard the snapshot, set avg_overrun, and leave the in-progress division unaffected.
- Reset mid-frame or mid-division returns everything to reset values. No partial result is emitted.
- Non-beat cycles (tvalid=0 or tready=0) change no accumulator state.

Test Plan:
- Reset, then frames of 100 beats (10x10, SOF every 100th), tdata constant 0x40_80_C0 -> after the 2nd SOF plus 29 cycles, avg_valid pulses with avg_color=0x4080C0; avg_overrun stays 0.
- Request filter 3 mid-frame -> req_ready drops; active_filter=3 and filter_changed pulse the cycle after the next SOF beat; req_ready returns to 1.
- num_filters=5, request 7 -> bad_req pulses; active_filter unchanged.
- auto_en=1, auto_period=2, num_filters=3, starting at 0 -> active_filter goes 1, 2, 0 on every 2nd SOF. A pending request 4 with num_filters=5 at a due SOF wins over auto, and frame_cnt restarts.
- Frame of 10 beats (shorter than the divide latency) -> the next snapshot is skipped, avg_overrun=1, and the earlier average completes correctly.
- Alternating pixels 0x000000 and 0xFFFFFF over 100 beats with tvalid toggling -> avg_color=0x7F7F7F (truncation); stalled cycles are not counted.
